// File: rtl/i281_pkg.sv
// Shared encodings for the i281 multi-cycle core: opcodes, FSM states, branch conditions,
// flag bit positions and instruction field positions.
package i281_pkg;

  typedef enum logic [3:0] {
    OP_NOOP   = 4'h0,
    OP_INPUTC = 4'h1,
    OP_MOVE   = 4'h2,
    OP_LOADI  = 4'h3,
    OP_ADD    = 4'h4,
    OP_ADDI   = 4'h5,
    OP_SUB    = 4'h6,
    OP_SUBI   = 4'h7,
    OP_LOAD   = 4'h8,
    OP_LOADF  = 4'h9,
    OP_STORE  = 4'hA,
    OP_STOREF = 4'hB,
    OP_SHIFT  = 4'hC,
    OP_CMP    = 4'hD,
    OP_JUMP   = 4'hE,
    OP_BRANCH = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    COND_C = 2'd0,
    COND_Z = 2'd1,
    COND_N = 2'd2,
    COND_V = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SHL = 2'd2,
    ALU_SHR = 2'd3
  } alu_op_e;

  // flags bus is {C,Z,N,V}
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam int IR_OP_HI  = 15;
  localparam int IR_OP_LO  = 12;
  localparam int IR_RX_HI  = 11;
  localparam int IR_RX_LO  = 10;
  localparam int IR_RY_HI  = 9;
  localparam int IR_RY_LO  = 8;
  localparam int IR_IMM_HI = 7;
  localparam int IR_IMM_LO = 0;

  // JUMP to itself (offset -1) is the halt idiom
  localparam logic [7:0] HALT_IMM = 8'hFF;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_INPUTC) || (op == OP_LOAD) || (op == OP_LOADF) ||
           (op == OP_STORE) || (op == OP_STOREF);
  endfunction

endpackage

// File: rtl/i281_alu_n.sv
// Combinational add/sub/shift unit for the i281 core; produces the result and {C,Z,N,V}.
// SUB carry is no-borrow; shifts report the bit shifted out in C and clear V.
module i281_alu_n
  import i281_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flg
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            carry;
  logic            ovf;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        res   = sum[DATA_W-1:0];
        carry = ~sum[DATA_W];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      ALU_SHL: begin
        res   = {a[DATA_W-2:0], 1'b0};
        carry = a[MSB];
      end
      default: begin
        res   = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
    endcase
    flg         = '0;
    flg[FLAG_C] = carry;
    flg[FLAG_Z] = (res == '0);
    flg[FLAG_N] = res[MSB];
    flg[FLAG_V] = ovf;
  end

endmodule

// File: rtl/i281_core_mc.sv
// i281 multi-cycle core: sequencer FSM, register file, flags and PC, with valid/ack code and
// data memory ports and run/step/halt control. Define I281_BREAKPOINT_EN for the PC breakpoint.
module i281_core_mc
  import i281_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 6,
  parameter int DMEM_AW = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [DATA_W-1:0]  switches,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               imem_valid,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         flags,
  output logic [2:0]         state,
`ifdef I281_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  output logic               bp_hit,
`endif
  output logic               halted
);

  state_e             state_q, state_d, retire_state;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc, pc_rel, exec_pc, pc_ret;
  logic [15:0]        ir_q, ir_d;
  logic [DATA_W-1:0]  regs_q [4];
  logic [DATA_W-1:0]  regs_d [4];
  logic [3:0]         flags_q, flags_d;
  logic               halted_q, halted_d;
  logic               single_q, single_d;
  logic               step_prev_q, step_prev_d;
  logic               req_q, req_d, we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d, mem_addr;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  opcode_e            op;
  logic [1:0]         rx, ry;
  logic [7:0]         imm;
  logic signed [7:0]  imm_s;
  logic [DATA_W-1:0]  imm_ext, rx_val, ry_val, alu_b, alu_res, eff_addr;
  logic [3:0]         alu_flg;
  alu_op_e            alu_op;
  logic               mem_op, load_op, halt_hit, br_taken, step_rise, bp_trip;

  // Instruction decode
  assign op        = opcode_e'(ir_q[IR_OP_HI:IR_OP_LO]);
  assign rx        = ir_q[IR_RX_HI:IR_RX_LO];
  assign ry        = ir_q[IR_RY_HI:IR_RY_LO];
  assign imm       = ir_q[IR_IMM_HI:IR_IMM_LO];
  assign imm_s     = ir_q[IR_IMM_HI:IR_IMM_LO];
  assign imm_ext   = DATA_W'(imm_s);
  assign rx_val    = regs_q[rx];
  assign ry_val    = regs_q[ry];
  assign mem_op    = is_mem_op(op);
  assign load_op   = (op == OP_LOAD) || (op == OP_LOADF);
  assign halt_hit  = (op == OP_JUMP) && (imm == HALT_IMM);
  assign step_rise = step && !step_prev_q;

  assign eff_addr  = ((op == OP_LOADF) || (op == OP_STOREF)) ? (ry_val + imm_ext) : imm_ext;
  assign mem_addr  = DMEM_AW'(eff_addr);

  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_rel    = pc_inc + PC_W'(imm_s);
  assign pc_ret    = (state_q == ST_MEM) ? pc_inc : exec_pc;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = ry_val;
    case (op)
      OP_ADDI:        alu_b  = imm_ext;
      OP_SUB, OP_CMP: alu_op = ALU_SUB;
      OP_SUBI: begin
        alu_op = ALU_SUB;
        alu_b  = imm_ext;
      end
      OP_SHIFT:       alu_op = imm[0] ? ALU_SHL : ALU_SHR;
      default:        ;
    endcase
  end

  i281_alu_n #(.DATA_W(DATA_W)) u_alu (
    .a   (rx_val),
    .b   (alu_b),
    .op  (alu_op),
    .res (alu_res),
    .flg (alu_flg)
  );

  always_comb begin
    br_taken = 1'b0;
    case (cond_e'(ry))
      COND_C: br_taken = flags_q[FLAG_C];
      COND_Z: br_taken = flags_q[FLAG_Z];
      COND_N: br_taken = flags_q[FLAG_N];
      COND_V: br_taken = flags_q[FLAG_V];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_pc = pc_inc;
    if (op == OP_JUMP || (op == OP_BRANCH && br_taken)) exec_pc = pc_rel;
  end

`ifdef I281_BREAKPOINT_EN
  logic retiring, bp_hit_q, bp_hit_d;

  // pc_ret != pc_q keeps a stopped breakpoint from re-firing until the PC moves
  assign retiring = ((state_q == ST_EXEC) && !mem_op && !halt_hit) ||
                    ((state_q == ST_MEM) && dmem_ack);
  assign bp_trip  = bp_en && (pc_ret == bp_addr) && (pc_ret != pc_q);
  assign bp_hit_d = retiring && run && !single_q && bp_trip;
  assign bp_hit   = bp_hit_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bp_hit_q <= 1'b0;
    else        bp_hit_q <= bp_hit_d;
  end
`else
  assign bp_trip = 1'b0;
`endif

  assign retire_state = (run && !single_q && !bp_trip) ? ST_FETCH : ST_STOP;

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_STOP;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (run || step_rise) state_d = ST_FETCH;
      ST_FETCH: if (imem_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (halt_hit)    state_d = ST_HALT;
        else if (mem_op) state_d = ST_MEM;
        else             state_d = retire_state;
      end
      ST_MEM:   if (dmem_ack) state_d = retire_state;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_STOP;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    halted_d    = halted_q;
    single_d    = single_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    step_prev_d = step;
    case (state_q)
      ST_STOP: begin
        if (run)            single_d = 1'b0;
        else if (step_rise) single_d = 1'b1;
      end
      ST_FETCH: if (imem_valid) ir_d = imem_rdata;
      ST_EXEC: begin
        if (halt_hit) begin
          halted_d = 1'b1;
        end else if (mem_op) begin
          req_d   = 1'b1;
          we_d    = !load_op;
          addr_d  = mem_addr;
          wdata_d = (op == OP_INPUTC) ? switches : rx_val;
        end else begin
          pc_d = pc_ret;
          case (op)
            OP_MOVE:  regs_d[rx] = ry_val;
            OP_LOADI: regs_d[rx] = imm_ext;
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_SHIFT: begin
              regs_d[rx] = alu_res;
              flags_d    = alu_flg;
            end
            OP_CMP:   flags_d = alu_flg;
            default:  ;
          endcase
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          pc_d  = pc_ret;
          if (load_op) regs_d[rx] = dmem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      ir_q        <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      flags_q     <= '0;
      halted_q    <= 1'b0;
      single_q    <= 1'b0;
      step_prev_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      halted_q    <= halted_d;
      single_q    <= single_d;
      step_prev_q <= step_prev_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // FSM: outputs
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign flags      = flags_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_i281_core_mc.sv
// Directed bench for i281_core_mc: an 8-bit core with wait-stated data memory and a 16-bit core.
module tb_i281_core_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic        step  = 1'b0;
  logic [7:0]  switches = 8'hA5;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_addr;
  logic [7:0]  dmem_wdata, dmem_rdata;
  logic [5:0]  pc;
  logic [3:0]  flags;
  logic [2:0]  state;
  logic        halted;

  logic [15:0] imem [64];
  logic [7:0]  dmem [16];
  int          ack_delay = 0;
  int          ack_cnt;
  int          wr_cnt = 0;
  logic [3:0]  wr_addr_last = '0;
  logic [7:0]  wr_data_last = '0;

  logic        run16 = 1'b0;
  logic [5:0]  imem_addr16, pc16;
  logic [15:0] imem_rdata16;
  logic        req16, we16, halted16;
  logic [3:0]  addr16, flags16;
  logic [15:0] wdata16, rdata16;
  logic [2:0]  state16;
  logic [15:0] imem16 [64];
  logic [15:0] dmem16 [16];

`ifdef I281_BREAKPOINT_EN
  logic       bp_en = 1'b0;
  logic [5:0] bp_addr = '0;
  logic       bp_hit, bp_hit16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign imem_rdata = imem[imem_addr];
  assign imem_valid = 1'b1;
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ack   = dmem_req && (ack_cnt == ack_delay);

  always @(posedge clock or negedge reset) begin
    if (!reset)                     ack_cnt <= 0;
    else if (dmem_req && !dmem_ack) ack_cnt <= ack_cnt + 1;
    else                            ack_cnt <= 0;
  end

  always @(posedge clock) begin
    if (reset && dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr] = dmem_wdata;
      wr_addr_last    = dmem_addr;
      wr_data_last    = dmem_wdata;
      wr_cnt          = wr_cnt + 1;
    end
  end

  assign imem_rdata16 = imem16[imem_addr16];
  assign rdata16      = dmem16[addr16];

  always @(posedge clock) begin
    if (reset && req16 && we16) dmem16[addr16] = wdata16;
  end

  i281_core_mc #(.DATA_W(8), .PC_W(6), .DMEM_AW(4)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .switches   (switches),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc         (pc),
    .flags      (flags),
    .state      (state),
`ifdef I281_BREAKPOINT_EN
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit),
`endif
    .halted     (halted)
  );

  i281_core_mc #(.DATA_W(16), .PC_W(6), .DMEM_AW(4)) u_dut16 (
    .clock      (clock),
    .reset      (reset),
    .run        (run16),
    .step       (1'b0),
    .switches   (16'h0000),
    .imem_addr  (imem_addr16),
    .imem_rdata (imem_rdata16),
    .imem_valid (1'b1),
    .dmem_req   (req16),
    .dmem_we    (we16),
    .dmem_addr  (addr16),
    .dmem_wdata (wdata16),
    .dmem_rdata (rdata16),
    .dmem_ack   (req16),
    .pc         (pc16),
    .flags      (flags16),
    .state      (state16),
`ifdef I281_BREAKPOINT_EN
    .bp_en      (1'b0),
    .bp_addr    (6'd0),
    .bp_hit     (bp_hit16),
`endif
    .halted     (halted16)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(halted), 32'h1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 16'hE0FF;
  endtask

  task automatic pulse_reset();
    run   = 1'b0;
    step  = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) dmem16[i] = 16'h0000;
    for (int i = 0; i < 64; i++) imem16[i] = 16'hE0FF;
    clear_imem();

    // Reset state
    #1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Reset while a load is waiting on ack
    imem[0] = 16'h3080;  // LOADI r0,0x80
    imem[1] = 16'h5080;  // ADDI  r0,0x80
    imem[2] = 16'h8402;  // LOAD  r1,[2]
    ack_delay = 100;
    run = 1'b1;
    wait_state(3'd3, 20, "midrun_reach_mem");
    chk("midrun_flags_cznv", 32'(flags), 32'hD);
    chk("midrun_req", 32'(dmem_req), 32'h1);
    chk("midrun_addr", 32'(dmem_addr), 32'h2);
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_flags", 32'(flags), 32'h0);
    chk("arst_req", 32'(dmem_req), 32'h0);
    chk("arst_addr", 32'(dmem_addr), 32'h0);
    run = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_imem_addr", 32'(imem_addr), 32'h0);
    chk("idle_state", 32'(state), 32'h0);

    // LOADI / ADDI / STORE, then halt
    clear_imem();
    imem[0] = 16'h3005;  // LOADI r0,5
    imem[1] = 16'h50FA;  // ADDI  r0,-6
    imem[2] = 16'hA003;  // STORE r0,[3]
    imem[3] = 16'hE0FF;  // JUMP  -1
    ack_delay = 0;
    run = 1'b1;
    wait_halt(40, "addi_halt");
    chk("addi_dmem3", 32'(dmem[3]), 32'hFF);
    chk("addi_wr_addr", 32'(wr_addr_last), 32'h3);
    chk("addi_wr_data", 32'(wr_data_last), 32'hFF);
    chk("addi_flags", 32'(flags), 32'h2);
    chk("addi_pc", 32'(pc), 32'h3);
    chk("addi_state", 32'(state), 32'h4);
    repeat (5) tick();
    step = 1'b1;
    repeat (2) tick();
    step = 1'b0;
    tick();
    chk("halt_pc_frozen", 32'(pc), 32'h3);
    chk("halt_state_held", 32'(state), 32'h4);
    chk("halt_sticky", 32'(halted), 32'h1);
    pulse_reset();

    // LOAD with ack three cycles late
    dmem[2] = 8'h5A;
    imem[0] = 16'h8402;  // LOAD  r1,[2]
    imem[1] = 16'hA404;  // STORE r1,[4]
    imem[2] = 16'hE0FF;
    ack_delay = 3;
    run = 1'b1;
    wait_state(3'd3, 10, "load_reach_mem");
    for (int i = 0; i < 3; i++) begin
      chk("load_wait_req", 32'(dmem_req), 32'h1);
      chk("load_wait_addr", 32'(dmem_addr), 32'h2);
      chk("load_wait_we", 32'(dmem_we), 32'h0);
      chk("load_wait_pc", 32'(pc), 32'h0);
      tick();
    end
    chk("load_ack_state", 32'(state), 32'h3);
    chk("load_ack_pc", 32'(pc), 32'h0);
    tick();
    chk("load_req_drop", 32'(dmem_req), 32'h0);
    chk("load_pc_once", 32'(pc), 32'h1);
    chk("load_refetch", 32'(state), 32'h1);
    wait_halt(40, "load_halt");
    chk("load_r1_stored", 32'(dmem[4]), 32'h5A);
    chk("load_final_pc", 32'(pc), 32'h2);
    pulse_reset();

    // Single step
    ack_delay = 0;
    clear_imem();
    imem[0] = 16'h3807;  // LOADI r2,7
    imem[1] = 16'h0000;  // NOOP
    step = 1'b1;
    tick();
    chk("step_fetch", 32'(state), 32'h1);
    tick();
    chk("step_exec", 32'(state), 32'h2);
    tick();
    chk("step_stop", 32'(state), 32'h0);
    chk("step_pc", 32'(pc), 32'h1);
    repeat (4) tick();
    chk("step_level_pc", 32'(pc), 32'h1);
    chk("step_level_state", 32'(state), 32'h0);
    step = 1'b0;
    tick();
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    chk("step2_pc", 32'(pc), 32'h2);
    chk("step2_state", 32'(state), 32'h0);
    pulse_reset();

    // Branch taken / not taken, then halt
    dmem[8] = 8'hEE;
    clear_imem();
    imem[0]  = 16'h3003;  // LOADI r0,3
    imem[1]  = 16'h3403;  // LOADI r1,3
    imem[2]  = 16'hD100;  // CMP   r0,r1
    imem[3]  = 16'hF102;  // BRANCH Z,+2 -> 6
    imem[4]  = 16'hA008;  // STORE r0,[8]
    imem[5]  = 16'hA008;  // STORE r0,[8]
    imem[6]  = 16'h3404;  // LOADI r1,4
    imem[7]  = 16'hD100;  // CMP   r0,r1
    imem[8]  = 16'hF102;  // BRANCH Z,+2 (not taken)
    imem[9]  = 16'hA409;  // STORE r1,[9]
    imem[10] = 16'hE0FF;
    run = 1'b1;
    wait_halt(80, "br_halt");
    chk("br_skip_dmem8", 32'(dmem[8]), 32'hEE);
    chk("br_fall_dmem9", 32'(dmem[9]), 32'h4);
    chk("br_flags", 32'(flags), 32'h2);
    chk("br_pc", 32'(pc), 32'hA);
    chk("br_state", 32'(state), 32'h4);
    repeat (5) tick();
    chk("br_no_fetch_pc", 32'(imem_addr), 32'hA);
    pulse_reset();

    // INPUTC, LOADF, SHIFT, MOVE, SUBI, STOREF, JUMP
    dmem[10] = 8'hCC;
    clear_imem();
    imem[0]  = 16'h1005;  // INPUTC [5]
    imem[1]  = 16'h3C01;  // LOADI  r3,1
    imem[2]  = 16'h9B04;  // LOADF  r2,[r3+4]
    imem[3]  = 16'hC800;  // SHIFT  r2 right
    imem[4]  = 16'h2600;  // MOVE   r1,r2
    imem[5]  = 16'h7460;  // SUBI   r1,0x60
    imem[6]  = 16'hB706;  // STOREF r1,[r3+6]
    imem[7]  = 16'hE001;  // JUMP   +1 -> 9
    imem[8]  = 16'hA40A;  // STORE  r1,[10]
    imem[9]  = 16'hC401;  // SHIFT  r1 left
    imem[10] = 16'hA40B;  // STORE  r1,[11]
    imem[11] = 16'hE0FF;
    run = 1'b1;
    wait_halt(80, "misc_halt");
    chk("misc_inputc", 32'(dmem[5]), 32'hA5);
    chk("misc_storef", 32'(dmem[7]), 32'hF2);
    chk("misc_jump_skip", 32'(dmem[10]), 32'hCC);
    chk("misc_shl", 32'(dmem[11]), 32'hE4);
    chk("misc_flags", 32'(flags), 32'hA);
    chk("misc_pc", 32'(pc), 32'hB);
    pulse_reset();

`ifdef I281_BREAKPOINT_EN
    begin : bp_test
      int n;
      clear_imem();
      for (int i = 0; i < 4; i++) imem[i] = 16'h0000;
      imem[4] = 16'hE0FF;
      bp_en   = 1'b1;
      bp_addr = 6'd2;
      run     = 1'b1;
      n = 0;
      while (bp_hit !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("bp_hit", 32'(bp_hit), 32'h1);
      chk("bp_state", 32'(state), 32'h0);
      chk("bp_pc", 32'(pc), 32'h2);
      tick();
      chk("bp_pulse", 32'(bp_hit), 32'h0);
      wait_halt(40, "bp_halt");
      chk("bp_final_pc", 32'(pc), 32'h4);
      bp_en = 1'b0;
      pulse_reset();
    end
`endif

    // 16-bit datapath: 0x7FFF + 1 overflows
    begin : w16_test
      int n;
      dmem16[0] = 16'h7FFF;
      imem16[0] = 16'h8000;  // LOAD  r0,[0]
      imem16[1] = 16'h5001;  // ADDI  r0,1
      imem16[2] = 16'hA001;  // STORE r0,[1]
      imem16[3] = 16'hE0FF;
      run16 = 1'b1;
      n = 0;
      while (halted16 !== 1'b1 && n < 60) begin
        tick();
        n++;
      end
      chk("w16_halt", 32'(halted16), 32'h1);
      chk("w16_result", 32'(dmem16[1]), 32'h8000);
      chk("w16_flags", 32'(flags16), 32'h3);
      chk("w16_pc", 32'(pc16), 32'h3);
      run16 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
